iic_req_arbiter: RTL and testbench
==================================

Name: iic_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single I2C master between two client requesters (e.g. sensor poller and LED/config logic). It latches the winning request, drives the master's start/RW/write-data inputs, waits for the master's completion, and returns the read byte and status to the winning client. A watchdog frees the bus if the master never completes.

Parameters:
DATA_W, 8, width of write/read data bytes.
TIMEOUT_CYC, 50000, max i_clk cycles from start assertion to i_iic_done before abort (1 ms at 50 MHz).
CNT_W, 16, width of watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
i_clk  in  1  system clock, all logic rising-edge.
i_rst  in  1  reset, asynchronous, active-high.
i_req  in  2  per-client request level; bit n = client n.
i_req_rw  in  2  per-client direction, 1 = read, 0 = write.
i_wdata0  in  DATA_W  client 0 write byte.
i_wdata1  in  DATA_W  client 1 write byte.
o_gnt  out  2  one-hot grant, high from latch until the ack cycle inclusive.
o_ack  out  2  one-cycle completion pulse to granted client.
o_err  out  1  valid with o_ack: 1 = NACK or timeout.
o_rdata  out  DATA_W  read byte, valid with o_ack on a read; holds last value otherwise.
o_iic_start  out  1  start request to I2C master.
o_iic_RW  out  1  direction to master.
o_iic_W_memory  out  DATA_W  write byte to master.
i_iic_busy  in  1  master transaction in progress.
i_iic_done  in  1  one-cycle pulse, master finished.
i_iic_nack  in  1  valid with i_iic_done: slave did not acknowledge.
i_iic_R_memory  in  DATA_W  master read byte, valid with i_iic_done.

Behaviour:
- Reset (async, i_rst=1): state IDLE; o_gnt=0, o_ack=0, o_err=0, o_rdata=0, o_iic_start=0, o_iic_RW=0, o_iic_W_memory=0; last-grant pointer=1 (client 0 wins first tie); watchdog=0. Reset mid-transaction aborts without ack; clients re-request.
- Client rule: hold i_req, i_req_rw, wdata stable until o_ack; deassert the cycle after o_ack or it is a new request.
- States: IDLE, ISSUE, WAIT_DONE, RESPOND.
- IDLE: if any i_req and i_iic_busy=0: pick winner (single request -> that client; both -> client != last pointer). Next edge: o_gnt one-hot, latch rw/wdata into o_iic_RW/o_iic_W_memory, o_iic_start=1, pointer=winner, watchdog cleared -> ISSUE. If i_iic_busy=1 in IDLE, stay (bus owned elsewhere).
- ISSUE: o_iic_start held high until first cycle i_iic_busy=1 sampled, then deasserted next edge -> WAIT_DONE. i_iic_done in ISSUE (short transfer) goes straight to RESPOND handling.
- WAIT_DONE: watchdog increments each cycle from ISSUE entry. On i_iic_done: capture i_iic_R_memory into o_rdata if read (writes leave o_rdata unchanged), o_err=i_iic_nack -> RESPOND. If watchdog reaches TIMEOUT_CYC-1 without done: o_iic_start=0, o_err=1, o_rdata unchanged -> RESPOND.
- RESPOND: one cycle; o_ack bit of winner=1, o_gnt still set; next edge o_ack=0, o_gnt=0, o_iic_start=0 -> IDLE.
- Minimum spacing: one IDLE cycle between consecutive grants; request-to-start latency 1 cycle; done-to-ack latency 1 cycle.
- Request dropped while granted: transaction completes, ack still issued.
- i_iic_done outside ISSUE/WAIT_DONE ignored.
- Watchdog saturates; never wraps.

Test Plan:
- Single write: i_req=01, rw=0, wdata0=0xA5 -> next cycle o_gnt=01, o_iic_start=1, o_iic_W_memory=0xA5, o_iic_RW=0; busy high then done with nack=0 -> o_ack=01 one cycle later, o_err=0.
- Single read: i_req=10, rw=1; done with R_memory=0x3C -> o_ack=10, o_rdata=0x3C, o_err=0.
- Contention: i_req=11 held continuously, ack each -> grants alternate 01,10,01,10; first grant 01 after reset.
- NACK: done with i_iic_nack=1 -> o_ack pulse, o_err=1, o_rdata unchanged.
- Timeout: TIMEOUT_CYC=100, busy never done -> o_ack at cycle 100 after start, o_err=1, o_iic_start=0, back to IDLE.
- Async reset mid-WAIT_DONE -> all outputs 0 immediately without clock, no ack; post-reset request serviced normally.

Source files
------------

// File: rtl/iic_req_arbiter.sv
// Round-robin arbiter and sequencer sharing one I2C master between two clients.
// Latches the winning request, drives the master, and returns status/read data with a watchdog.
module iic_req_arbiter #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_req,
  input  logic [1:0]        i_req_rw,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic [1:0]        o_gnt,
  output logic [1:0]        o_ack,
  output logic              o_err,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_iic_start,
  output logic              o_iic_RW,
  output logic [DATA_W-1:0] o_iic_W_memory,
  input  logic              i_iic_busy,
  input  logic              i_iic_done,
  input  logic              i_iic_nack,
  input  logic [DATA_W-1:0] i_iic_R_memory
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StRespond
  } state_e;

  localparam logic [CNT_W-1:0] WdLast = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] WdMax  = '1;

  state_e            state_q;
  logic [1:0]        gnt_q;
  logic [1:0]        ack_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              start_q;
  logic              rw_q;
  logic [DATA_W-1:0] wmem_q;
  logic              last_q;
  logic [CNT_W-1:0]  wd_q;

  logic              win_d;
  logic              wd_expired;

  // On a tie the client that did not win last time takes the bus.
  always_comb begin
    win_d = 1'b0;
    case (i_req)
      2'b01:   win_d = 1'b0;
      2'b10:   win_d = 1'b1;
      2'b11:   win_d = ~last_q;
      default: win_d = 1'b0;
    endcase
  end

  assign wd_expired = (wd_q >= WdLast);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      gnt_q   <= 2'b00;
      ack_q   <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= '0;
      start_q <= 1'b0;
      rw_q    <= 1'b0;
      wmem_q  <= '0;
      last_q  <= 1'b1;
      wd_q    <= '0;
    end else begin
      ack_q <= 2'b00;
      case (state_q)
        StIdle: begin
          if ((|i_req) && !i_iic_busy) begin
            gnt_q   <= win_d ? 2'b10 : 2'b01;
            rw_q    <= i_req_rw[win_d];
            wmem_q  <= win_d ? i_wdata1 : i_wdata0;
            start_q <= 1'b1;
            last_q  <= win_d;
            wd_q    <= '0;
            state_q <= StIssue;
          end
        end
        StIssue, StWaitDone: begin
          if (wd_q != WdMax) begin
            wd_q <= wd_q + CNT_W'(1);
          end
          if (i_iic_done) begin
            start_q <= 1'b0;
            ack_q   <= gnt_q;
            err_q   <= i_iic_nack;
            if (rw_q) begin
              rdata_q <= i_iic_R_memory;
            end
            state_q <= StRespond;
          end else if (wd_expired) begin
            start_q <= 1'b0;
            ack_q   <= gnt_q;
            err_q   <= 1'b1;
            state_q <= StRespond;
          end else if ((state_q == StIssue) && i_iic_busy) begin
            start_q <= 1'b0;
            state_q <= StWaitDone;
          end
        end
        StRespond: begin
          gnt_q   <= 2'b00;
          start_q <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          gnt_q   <= 2'b00;
          start_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_gnt          = gnt_q;
  assign o_ack          = ack_q;
  assign o_err          = err_q;
  assign o_rdata        = rdata_q;
  assign o_iic_start    = start_q;
  assign o_iic_RW       = rw_q;
  assign o_iic_W_memory = wmem_q;

endmodule

// File: tb/tb_iic_req_arbiter.sv
// Bench for iic_req_arbiter: directed vector table, random transactions against a
// transaction-level round-robin model, and hand sequences for timeout, busy bus and reset.
module tb_iic_req_arbiter;

  localparam int unsigned DataW   = 8;
  localparam int unsigned Timeout = 100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req = 2'b00;
  logic [1:0]       req_rw = 2'b00;
  logic [DataW-1:0] wdata0 = '0;
  logic [DataW-1:0] wdata1 = '0;
  logic [1:0]       gnt;
  logic [1:0]       ack;
  logic             err;
  logic [DataW-1:0] rdata;
  logic             start;
  logic             rw_o;
  logic [DataW-1:0] wmem;
  logic             busy = 1'b0;
  logic             done = 1'b0;
  logic             nack = 1'b0;
  logic [DataW-1:0] rmem = '0;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  int               model_last  = 1;
  logic [DataW-1:0] model_rdata = '0;

  iic_req_arbiter #(
    .DATA_W     (DataW),
    .TIMEOUT_CYC(Timeout),
    .CNT_W      (16)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .i_req_rw      (req_rw),
    .i_wdata0      (wdata0),
    .i_wdata1      (wdata1),
    .o_gnt         (gnt),
    .o_ack         (ack),
    .o_err         (err),
    .o_rdata       (rdata),
    .o_iic_start   (start),
    .o_iic_RW      (rw_o),
    .o_iic_W_memory(wmem),
    .i_iic_busy    (busy),
    .i_iic_done    (done),
    .i_iic_nack    (nack),
    .i_iic_R_memory(rmem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       req;
    logic [1:0]       rw;
    logic [DataW-1:0] w0;
    logic [DataW-1:0] w1;
    logic             nack;
    logic [DataW-1:0] rm;
    int               lat;
    bit               short_t;
    logic [1:0]       gnt;
    logic             rw_exp;
    logic [DataW-1:0] w_exp;
    logic             err;
    logic [DataW-1:0] rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [1:0] r, input int last);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
    return 1 - last;
  endfunction

  // Starts and ends on a falling edge with the DUT idle.
  task automatic run_txn(input vec_t v, input string tag);
    req    = v.req;
    req_rw = v.rw;
    wdata0 = v.w0;
    wdata1 = v.w1;
    @(negedge clk);
    chk({tag, " gnt"}, 32'(gnt), 32'(v.gnt));
    chk({tag, " start"}, 32'(start), 32'd1);
    chk({tag, " RW"}, 32'(rw_o), 32'(v.rw_exp));
    chk({tag, " W_memory"}, 32'(wmem), 32'(v.w_exp));
    if (!v.short_t) begin
      busy = 1'b1;
      @(negedge clk);
      chk({tag, " start drop"}, 32'(start), 32'd0);
      repeat (v.lat) @(negedge clk);
      chk({tag, " no early ack"}, 32'(ack), 32'd0);
    end
    busy = 1'b0;
    done = 1'b1;
    nack = v.nack;
    rmem = v.rm;
    @(negedge clk);
    done = 1'b0;
    nack = 1'b0;
    req  = 2'b00;
    chk({tag, " ack"}, 32'(ack), 32'(v.gnt));
    chk({tag, " gnt@ack"}, 32'(gnt), 32'(v.gnt));
    chk({tag, " err"}, 32'(err), 32'(v.err));
    chk({tag, " rdata"}, 32'(rdata), 32'(v.rdata));
    @(negedge clk);
    chk({tag, " ack off"}, 32'(ack), 32'd0);
    chk({tag, " gnt off"}, 32'(gnt), 32'd0);
  endtask

  initial begin
    vec_t v;
    int   w;
    int   cnt;

    vecs[0] = '{2'b01, 2'b00, 8'hA5, 8'h00, 1'b0, 8'hFF, 3, 1'b0, 2'b01, 1'b0, 8'hA5, 1'b0, 8'h00};
    vecs[1] = '{2'b10, 2'b10, 8'h11, 8'h22, 1'b0, 8'h3C, 2, 1'b0, 2'b10, 1'b1, 8'h22, 1'b0, 8'h3C};
    vecs[2] = '{2'b11, 2'b00, 8'h01, 8'h02, 1'b0, 8'hEE, 1, 1'b0, 2'b01, 1'b0, 8'h01, 1'b0, 8'h3C};
    vecs[3] = '{2'b11, 2'b11, 8'h03, 8'h04, 1'b0, 8'h5A, 4, 1'b0, 2'b10, 1'b1, 8'h04, 1'b0, 8'h5A};
    vecs[4] = '{2'b11, 2'b01, 8'h05, 8'h06, 1'b0, 8'h77, 0, 1'b0, 2'b01, 1'b1, 8'h05, 1'b0, 8'h77};
    vecs[5] = '{2'b11, 2'b01, 8'h07, 8'h08, 1'b0, 8'h88, 2, 1'b0, 2'b10, 1'b0, 8'h08, 1'b0, 8'h77};
    vecs[6] = '{2'b01, 2'b00, 8'h09, 8'h0A, 1'b1, 8'h44, 1, 1'b0, 2'b01, 1'b0, 8'h09, 1'b1, 8'h77};
    vecs[7] = '{2'b10, 2'b10, 8'h0B, 8'h0C, 1'b0, 8'hC3, 0, 1'b1, 2'b10, 1'b1, 8'h0C, 1'b0, 8'hC3};

    #1;
    chk("reset gnt", 32'(gnt), 32'd0);
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset rdata", 32'(rdata), 32'd0);
    chk("reset start", 32'(start), 32'd0);
    chk("reset RW", 32'(rw_o), 32'd0);
    chk("reset W_memory", 32'(wmem), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
      model_last  = vecs[i].gnt[1] ? 1 : 0;
      model_rdata = vecs[i].rdata;
    end

    for (int i = 0; i < 40; i++) begin
      v.req     = 2'($urandom_range(1, 3));
      v.rw      = 2'($urandom_range(0, 3));
      v.w0      = 8'($urandom);
      v.w1      = 8'($urandom);
      v.rm      = 8'($urandom);
      v.lat     = int'($urandom_range(0, 5));
      v.short_t = ($urandom_range(0, 7) == 0);
      w         = pick(v.req, model_last);
      model_last = w;
      v.gnt     = (w == 1) ? 2'b10 : 2'b01;
      v.rw_exp  = v.rw[w];
      v.w_exp   = (w == 1) ? v.w1 : v.w0;
      v.nack    = v.rw_exp ? 1'b0 : 1'($urandom_range(0, 1));
      v.err     = v.nack;
      if (v.rw_exp) model_rdata = v.rm;
      v.rdata   = model_rdata;
      run_txn(v, $sformatf("rnd%0d", i));
    end

    // Bus owned elsewhere: no grant while busy, then normal grant once free.
    busy = 1'b1;
    req  = 2'b11;
    repeat (3) begin
      @(negedge clk);
      chk("busy idle gnt", 32'(gnt), 32'd0);
      chk("busy idle start", 32'(start), 32'd0);
    end
    busy = 1'b0;
    req  = 2'b00;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    chk("stray done ack", 32'(ack), 32'd0);

    // Watchdog: master goes busy and never completes.
    w = pick(2'b01, model_last);
    model_last = w;
    req    = 2'b01;
    req_rw = 2'b01;
    wdata0 = 8'h33;
    @(negedge clk);
    chk("to gnt", 32'(gnt), 32'd1);
    busy = 1'b1;
    cnt  = 0;
    while (ack == 2'b00 && cnt < 3 * Timeout) begin
      @(negedge clk);
      cnt++;
    end
    req = 2'b00;
    chk("to latency", 32'(cnt), 32'(Timeout));
    chk("to ack", 32'(ack), 32'd1);
    chk("to err", 32'(err), 32'd1);
    chk("to start", 32'(start), 32'd0);
    chk("to rdata", 32'(rdata), 32'(model_rdata));
    busy = 1'b0;
    @(negedge clk);
    chk("to ack off", 32'(ack), 32'd0);
    chk("to gnt off", 32'(gnt), 32'd0);

    // Async reset in the middle of a transfer.
    req    = 2'b10;
    req_rw = 2'b10;
    @(negedge clk);
    chk("rst txn gnt", 32'(gnt), 32'(2'b10));
    busy = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst  = 1'b1;
    req  = 2'b00;
    busy = 1'b0;
    #1;
    chk("async rst gnt", 32'(gnt), 32'd0);
    chk("async rst ack", 32'(ack), 32'd0);
    chk("async rst start", 32'(start), 32'd0);
    chk("async rst RW", 32'(rw_o), 32'd0);
    chk("async rst W_memory", 32'(wmem), 32'd0);
    chk("async rst rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post rst ack", 32'(ack), 32'd0);
    model_last  = 1;
    model_rdata = '0;
    v = '{2'b11, 2'b01, 8'h61, 8'h62, 1'b0, 8'h5E, 2, 1'b0, 2'b01, 1'b1, 8'h61, 1'b0, 8'h5E};
    run_txn(v, "post rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
